lsu_rmw: RTL and testbench

LSU_RMW -- requirements
Module: lsu_rmw

---
 rtl/lsu_rmw.sv | 248 ++++++++++++++++++++++++
 tb/tb_lsu_rmw.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
// Load/store unit with read-modify-write merging for sub-word and misaligned
// stores. Accepts one RV32I-style access at a time and turns it into one or
// two full-word bus transactions. Misaligned accesses that cross a bus word
// are split into two words or rejected, depending on MISALIGN_EN.
module lsu_rmw #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MISALIGN_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int WIN_W = 2 * DATA_W;
   localparam int WIN_B = 2 * NB;
   localparam logic [4:0] NB5 = 5'(NB);

   typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [DATA_W-1:0] word0_q;
   logic [DATA_W-1:0] word1_q;

   logic              accept;
   logic              req_cross;
   logic              req_err;
   logic              req_full;
   logic              cross_q;
   logic [OFF_W-1:0]  off_q;
   logic [OFF_W+2:0]  shamt;
   logic [ADDR_W-1:0] word0_addr;
   logic [ADDR_W-1:0] word1_addr;
   logic [WIN_W-1:0]  win;
   logic [WIN_B-1:0]  bmask;
   logic [WIN_W-1:0]  wmask;
   logic [WIN_W-1:0]  wshift;
   logic [WIN_W-1:0]  merged;
   logic [31:0]       raw;
   logic [31:0]       load_val;

   // Access size in bytes from the low funct3 bits (B=1, H=2, W=4)
   function automatic logic [4:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_of = 5'd1;
         2'b01:   size_of = 5'd2;
         default: size_of = 5'd4;
      endcase
   endfunction

   // Encodings that have no meaning for the given direction
   function automatic logic illegal_of(input logic we, input logic [2:0] f3);
      if (we)
         illegal_of = f3[2] | (f3[1:0] == 2'b11);
      else
         illegal_of = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
   endfunction

   // True when the access spills past the end of its bus word
   function automatic logic crosses(input logic [ADDR_W-1:0] a, input logic [2:0] f3);
      logic [4:0] off_ext;
      off_ext = 5'(a[OFF_W-1:0]);
      crosses = (off_ext + size_of(f3)) > NB5;
   endfunction

   assign accept    = req_valid & (state == IDLE);
   assign req_cross = crosses(req_addr, req_funct3);
   assign req_err   = illegal_of(req_we, req_funct3) | (req_cross & (MISALIGN_EN == 0));
   assign req_full  = (size_of(req_funct3) == NB5) && (req_addr[OFF_W-1:0] == '0);

   assign cross_q    = crosses(addr_q, funct3_q);
   assign off_q      = addr_q[OFF_W-1:0];
   assign shamt      = {off_q, 3'b000};
   assign word0_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign word1_addr = word0_addr + ADDR_W'(NB);
   assign win        = {word1_q, word0_q};

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state sequencing: optional reads, optional writes, then one response cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)
                  state_nxt = RESP;
               else if (req_we && req_full)
                  state_nxt = WR0;
               else
                  state_nxt = RD0;
            end
         end
         RD0: begin
            if (bus_ready) begin
               if (cross_q)
                  state_nxt = RD1;
               else if (we_q)
                  state_nxt = WR0;
               else
                  state_nxt = RESP;
            end
         end
         RD1: begin
            if (bus_ready) begin
               if (we_q)
                  state_nxt = WR0;
               else
                  state_nxt = RESP;
            end
         end
         WR0: begin
            if (bus_ready) begin
               if (cross_q)
                  state_nxt = WR1;
               else
                  state_nxt = RESP;
            end
         end
         WR1: begin
            if (bus_ready)
               state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture at accept and read-word capture on each completed read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         word0_q  <= '0;
         word1_q  <= '0;
      end else begin
         if (accept) begin
            addr_q   <= req_addr;
            we_q     <= req_we;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            word0_q  <= '0;
            word1_q  <= '0;
         end
         if (state == RD0 && bus_ready)
            word0_q <= bus_rdata;
         if (state == RD1 && bus_ready)
            word1_q <= bus_rdata;
      end
   end

   // Byte-lane merge over the two-word window and load extraction/extension
   always_comb begin
      bmask = '0;
      wmask = '0;
      case (funct3_q[1:0])
         2'b00:   bmask = WIN_B'(4'b0001);
         2'b01:   bmask = WIN_B'(4'b0011);
         default: bmask = WIN_B'(4'b1111);
      endcase
      bmask = bmask << off_q;
      for (int i = 0; i < WIN_B; i++)
         wmask[i*8 +: 8] = {8{bmask[i]}};
      wshift = WIN_W'(wdata_q) << shamt;
      merged = (win & ~wmask) | (wshift & wmask);
      raw    = 32'(win >> shamt);
      case (funct3_q)
         3'b000:  load_val = {{24{raw[7]}}, raw[7:0]};
         3'b001:  load_val = {{16{raw[15]}}, raw[15:0]};
         3'b100:  load_val = {24'd0, raw[7:0]};
         3'b101:  load_val = {16'd0, raw[15:0]};
         default: load_val = raw;
      endcase
   end

   // Bus and response outputs decoded from state so reset clears them at once
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      resp_err   = 1'b0;
      resp_rdata = '0;
      bus_valid  = 1'b0;
      bus_we     = 1'b0;
      bus_addr   = '0;
      bus_wdata  = '0;
      case (state)
         RD0: begin
            bus_valid = 1'b1;
            bus_addr  = word0_addr;
         end
         RD1: begin
            bus_valid = 1'b1;
            bus_addr  = word1_addr;
         end
         WR0: begin
            bus_valid = 1'b1;
            bus_we    = 1'b1;
            bus_addr  = word0_addr;
            bus_wdata = merged[DATA_W-1:0];
         end
         WR1: begin
            bus_valid = 1'b1;
            bus_we    = 1'b1;
            bus_addr  = word1_addr;
            bus_wdata = merged[WIN_W-1:DATA_W];
         end
         RESP: begin
            resp_err = err_q;
            if (!we_q && !err_q)
               resp_rdata = load_val;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: one instance with misaligned splitting enabled,
// one with it disabled, a word-indexed memory model and hand-computed results.
module tb_lsu_rmw;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b010;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        bus_ready = 1'b1;
   logic        sel = 1'b0;

   logic        req_valid_a = 1'b0, req_ready_a, resp_valid_a, resp_err_a;
   logic [31:0] resp_rdata_a;
   logic        bus_valid_a, bus_we_a;
   logic [31:0] bus_addr_a, bus_wdata_a, bus_rdata_a;

   logic        req_valid_b = 1'b0, req_ready_b, resp_valid_b, resp_err_b;
   logic [31:0] resp_rdata_b;
   logic        bus_valid_b, bus_we_b;
   logic [31:0] bus_addr_b, bus_wdata_b, bus_rdata_b;

   logic [31:0] mem [0:15];

   int          checks = 0;
   int          failures = 0;

   logic        res_valid;
   logic [31:0] res_rdata;
   logic        res_err;
   int          res_cycles;
   int          tx_n;
   logic [31:0] tx_addr [0:7];
   logic [31:0] tx_data [0:7];
   logic        tx_we   [0:7];
   logic        saw_resp;

   wire         req_ready_s  = sel ? req_ready_b  : req_ready_a;
   wire         resp_valid_s = sel ? resp_valid_b : resp_valid_a;
   wire         resp_err_s   = sel ? resp_err_b   : resp_err_a;
   wire [31:0]  resp_rdata_s = sel ? resp_rdata_b : resp_rdata_a;
   wire         bus_valid_s  = sel ? bus_valid_b  : bus_valid_a;
   wire         bus_we_s     = sel ? bus_we_b     : bus_we_a;
   wire [31:0]  bus_addr_s   = sel ? bus_addr_b   : bus_addr_a;
   wire [31:0]  bus_wdata_s  = sel ? bus_wdata_b  : bus_wdata_a;

   assign bus_rdata_a = mem[bus_addr_a[5:2]];
   assign bus_rdata_b = mem[bus_addr_b[5:2]];

   lsu_rmw #(.ADDR_W(32), .DATA_W(32), .MISALIGN_EN(1)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
      .bus_valid(bus_valid_a), .bus_ready(bus_ready), .bus_we(bus_we_a),
      .bus_addr(bus_addr_a), .bus_wdata(bus_wdata_a), .bus_rdata(bus_rdata_a)
   );

   lsu_rmw #(.ADDR_W(32), .DATA_W(32), .MISALIGN_EN(0)) u_dut_noalign (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
      .bus_valid(bus_valid_b), .bus_ready(bus_ready), .bus_we(bus_we_b),
      .bus_addr(bus_addr_b), .bus_wdata(bus_wdata_b), .bus_rdata(bus_rdata_b)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Hard stop in case the stimulus ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] simulation timed out");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one request to the selected instance and watch it until the response
   task automatic applyStimulus(input logic s, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd, input int stalls);
      int stall_left;
      stall_left = stalls;
      tx_n       = 0;
      res_valid  = 1'b0;
      res_rdata  = '0;
      res_err    = 1'b0;
      res_cycles = 0;
      @(negedge clk);
      sel         = s;
      bus_ready   = 1'b1;
      req_we      = we;
      req_funct3  = f3;
      req_addr    = addr;
      req_wdata   = wd;
      req_valid_a = !s;
      req_valid_b = s;
      @(posedge clk);
      @(negedge clk);
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      req_addr    = 32'hDEAD0000;
      req_wdata   = ~wd;
      req_funct3  = 3'b111;
      req_we      = ~we;
      for (int c = 1; c <= 40 && !res_valid; c++) begin
         if (bus_valid_s && stall_left > 0) begin
            bus_ready = 1'b0;
            stall_left--;
         end else begin
            bus_ready = 1'b1;
         end
         if (bus_valid_s && bus_ready && tx_n < 8) begin
            tx_addr[tx_n] = bus_addr_s;
            tx_data[tx_n] = bus_wdata_s;
            tx_we[tx_n]   = bus_we_s;
            tx_n++;
         end
         if (resp_valid_s) begin
            res_valid  = 1'b1;
            res_rdata  = resp_rdata_s;
            res_err    = resp_err_s;
            res_cycles = c;
         end else begin
            @(negedge clk);
         end
      end
      bus_ready = 1'b1;
   endtask

   task automatic expectResp(input string tag, input logic [31:0] rdata, input logic err,
                             input int cycles, input int ntx);
      checkOutput({tag, "_resp"}, 32'(res_valid), 32'd1);
      checkOutput({tag, "_rdata"}, res_rdata, rdata);
      checkOutput({tag, "_err"}, 32'(res_err), 32'(err));
      checkOutput({tag, "_lat"}, 32'(res_cycles), 32'(cycles));
      checkOutput({tag, "_ntx"}, 32'(tx_n), 32'(ntx));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;

      // Outputs while reset is held
      #12;
      checkOutput("rst_ready", 32'(req_ready_a), 32'd1);
      checkOutput("rst_resp_valid", 32'(resp_valid_a), 32'd0);
      checkOutput("rst_resp_err", 32'(resp_err_a), 32'd0);
      checkOutput("rst_resp_rdata", resp_rdata_a, 32'd0);
      checkOutput("rst_bus_valid", 32'(bus_valid_a), 32'd0);
      checkOutput("rst_bus_we", 32'(bus_we_a), 32'd0);
      checkOutput("rst_bus_addr", bus_addr_a, 32'd0);
      checkOutput("rst_bus_wdata", bus_wdata_a, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Aligned word load
      mem[0] = 32'hDEADBEEF;
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 0);
      expectResp("lw", 32'hDEADBEEF, 1'b0, 2, 1);
      checkOutput("lw_addr", tx_addr[0], 32'h100);
      checkOutput("lw_we", 32'(tx_we[0]), 32'd0);

      // Sub-word loads and extension
      mem[0] = 32'h80000000;
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 0);
      expectResp("lb", 32'hFFFFFF80, 1'b0, 2, 1);
      applyStimulus(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 0);
      expectResp("lbu", 32'h00000080, 1'b0, 2, 1);
      applyStimulus(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 0);
      expectResp("lh", 32'hFFFF8000, 1'b0, 2, 1);
      applyStimulus(1'b0, 1'b0, 3'b101, 32'h102, 32'h0, 0);
      expectResp("lhu", 32'h00008000, 1'b0, 2, 1);

      // Byte store read-modify-write
      mem[0] = 32'h11223344;
      applyStimulus(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 0);
      expectResp("sb", 32'h0, 1'b0, 3, 2);
      checkOutput("sb_rd_addr", tx_addr[0], 32'h100);
      checkOutput("sb_rd_we", 32'(tx_we[0]), 32'd0);
      checkOutput("sb_wr_addr", tx_addr[1], 32'h100);
      checkOutput("sb_wr_we", 32'(tx_we[1]), 32'd1);
      checkOutput("sb_wr_data", tx_data[1], 32'h1122AB44);

      // Misaligned load across two words
      mem[15] = 32'hAABBCCDD;
      mem[0]  = 32'h11223344;
      applyStimulus(1'b0, 1'b0, 3'b010, 32'hFE, 32'h0, 0);
      expectResp("lw_mis", 32'h3344AABB, 1'b0, 3, 2);
      checkOutput("lw_mis_a0", tx_addr[0], 32'hFC);
      checkOutput("lw_mis_a1", tx_addr[1], 32'h100);

      // Misaligned load wrapping the address space
      applyStimulus(1'b0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0);
      expectResp("lw_wrap", 32'h3344AABB, 1'b0, 3, 2);
      checkOutput("lw_wrap_a0", tx_addr[0], 32'hFFFFFFFC);
      checkOutput("lw_wrap_a1", tx_addr[1], 32'h00000000);

      // Misaligned halfword store: two reads then two merged writes
      applyStimulus(1'b0, 1'b1, 3'b001, 32'hFF, 32'h0000BEEF, 0);
      expectResp("sh_mis", 32'h0, 1'b0, 5, 4);
      checkOutput("sh_mis_w0_addr", tx_addr[2], 32'hFC);
      checkOutput("sh_mis_w0_data", tx_data[2], 32'hEFBBCCDD);
      checkOutput("sh_mis_w1_addr", tx_addr[3], 32'h100);
      checkOutput("sh_mis_w1_data", tx_data[3], 32'h112233BE);

      // Aligned word store skips the read
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h100, 32'h12345678, 0);
      expectResp("sw", 32'h0, 1'b0, 2, 1);
      checkOutput("sw_we", 32'(tx_we[0]), 32'd1);
      checkOutput("sw_data", tx_data[0], 32'h12345678);

      // Bus stall cycles add latency one for one
      mem[0] = 32'hCAFEF00D;
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 3);
      expectResp("lw_stall", 32'hCAFEF00D, 1'b0, 5, 1);

      // Illegal encodings
      applyStimulus(1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 0);
      expectResp("ld_bad", 32'h0, 1'b1, 1, 0);
      applyStimulus(1'b0, 1'b1, 3'b100, 32'h100, 32'h55, 0);
      expectResp("st_bad", 32'h0, 1'b1, 1, 0);

      // Instance with misaligned access rejected
      applyStimulus(1'b1, 1'b1, 3'b010, 32'h102, 32'h55, 0);
      expectResp("na_sw_mis", 32'h0, 1'b1, 1, 0);
      applyStimulus(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0);
      expectResp("na_ld_bad", 32'h0, 1'b1, 1, 0);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
      expectResp("na_lw", 32'hCAFEF00D, 1'b0, 2, 1);

      // Reset while a read is stalled
      sel = 1'b0;
      @(negedge clk);
      bus_ready   = 1'b0;
      req_we      = 1'b0;
      req_funct3  = 3'b010;
      req_addr    = 32'h100;
      req_valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_a = 1'b0;
      checkOutput("rmid_busvalid", 32'(bus_valid_a), 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("rmid_stall_valid", 32'(bus_valid_a), 32'd1);
      checkOutput("rmid_stall_addr", bus_addr_a, 32'h100);
      #2 reset = 1'b1;
      #1;
      checkOutput("rmid_drop", 32'(bus_valid_a), 32'd0);
      checkOutput("rmid_ready_in_rst", 32'(req_ready_a), 32'd1);
      saw_resp = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (resp_valid_a) saw_resp = 1'b1;
      end
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (resp_valid_a) saw_resp = 1'b1;
      end
      bus_ready = 1'b1;
      checkOutput("rmid_noresp", 32'(saw_resp), 32'd0);
      checkOutput("rmid_ready", 32'(req_ready_a), 32'd1);

      // Normal operation after the abandoned transaction
      mem[0] = 32'h7F00AA55;
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h100, 32'h0, 0);
      expectResp("post_rst_lb", 32'h00000055, 1'b0, 2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
